rtc_bus_engine: RTL and testbench

- Physical-layer bus master for the external RTC chip's multiplexed address/data bus (CS, AD/ALE address strobe, RD, WR, 8-bit AD).
- Executes one single-byte read or write transaction per command.
- Commands come from the sequencing FSM and its sub-controllers: data extraction, init/format/crono-start, time/date/crono save.
- Sits between the selmuxctr-selected command source and the chip pins; owns all pin timing so the upstream FSM only issues start/addr/data and waits for done.

---
 rtl/rtc_bus_engine_pkg.sv | 47 ++++
 rtl/rtc_bus_engine_if.sv | 29 ++
 rtl/rtc_bus_engine_phase_cnt.sv | 32 +++
 rtl/rtc_bus_engine.sv | 137 +++++++++++++
 tb/tb_rtc_bus_engine.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_bus_engine_pkg.sv
// Shared types and constants for the RTC multiplexed-bus engine and its users.
package rtc_bus_pkg;

  // One state per bus phase; each phase lasts a programmable number of cycles.
  typedef enum logic [2:0] {IDLE, ADDR, AHOLD, TURN, STB, DHOLD, REC} rtc_state_e;

  // Default phase lengths in clock cycles (each must be 1..255).
  localparam int T_ALE_DEF  = 2;
  localparam int T_AH_DEF   = 2;
  localparam int T_TURN_DEF = 2;
  localparam int T_STB_DEF  = 4;
  localparam int T_DH_DEF   = 2;
  localparam int T_REC_DEF  = 4;

  // RTC register map.
  localparam logic [7:0] RTC_REG_STATUS  = 8'h00;
  localparam logic [7:0] RTC_REG_SECONDS = 8'h21;
  localparam logic [7:0] RTC_REG_MINUTES = 8'h22;
  localparam logic [7:0] RTC_REG_HOURS   = 8'h23;
  localparam logic [7:0] RTC_REG_DAY     = 8'h24;
  localparam logic [7:0] RTC_REG_MONTH   = 8'h25;
  localparam logic [7:0] RTC_REG_YEAR    = 8'h26;
  localparam logic [7:0] RTC_REG_CRONO0  = 8'h41;
  localparam logic [7:0] RTC_REG_CRONO1  = 8'h42;
  localparam logic [7:0] RTC_REG_CRONO2  = 8'h43;
  localparam logic [7:0] RTC_REG_CMD     = 8'hF0;

  // Chip-side pin bundle, registered as a unit.
  typedef struct packed {
    logic       cs_n;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
    logic       ad_oe;
    logic [7:0] ad_o;
  } rtc_pins_t;

  // All pins inactive; the AD drive value is parked at zero when not driven.
  localparam rtc_pins_t PINS_IDLE = '{cs_n: 1'b1, ale: 1'b0, rd_n: 1'b1, wr_n: 1'b1,
                                      ad_oe: 1'b0, ad_o: 8'h00};

  // Counter load value for a phase of t cycles (phase ends when the count hits zero).
  function automatic logic [7:0] phase_load(input int t);
    return 8'(t - 1);
  endfunction

endpackage

// File: rtl/rtc_bus_engine_if.sv
// Command side (upstream FSM) plus chip pin side of the RTC bus engine.
interface rtc_bus_engine_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       cs_n;
  logic       ale;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] ad_o;
  logic       ad_oe;
  logic [7:0] ad_i;

  // Engine view: takes commands and the sampled AD bus, drives status and pins.
  modport master (
    input  start, rw, addr, wdata, ad_i,
    output ready, done, rdata, cs_n, ale, rd_n, wr_n, ad_o, ad_oe
  );

  // Upstream/chip view.
  modport slave (
    output start, rw, addr, wdata, ad_i,
    input  ready, done, rdata, cs_n, ale, rd_n, wr_n, ad_o, ad_oe
  );
endinterface

// File: rtl/rtc_bus_engine_phase_cnt.sv
// Loadable 8-bit down-counter timing every bus phase; zero marks the last cycle.
module rtc_phase_cnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);
  logic [7:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 8'h00)) begin
      cnt_d = cnt_q - 8'h01;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 8'h00);
endmodule

// File: rtl/rtc_bus_engine.sv
// Single-byte read/write bus master for the RTC chip's multiplexed AD bus.
// Every output is registered from the next-state decode, so pins change on
// the edge that enters a phase and never glitch.
module rtc_bus_engine
  import rtc_bus_pkg::*;
#(
  parameter int T_ALE  = T_ALE_DEF,
  parameter int T_AH   = T_AH_DEF,
  parameter int T_TURN = T_TURN_DEF,
  parameter int T_STB  = T_STB_DEF,
  parameter int T_DH   = T_DH_DEF,
  parameter int T_REC  = T_REC_DEF
) (
  input logic               clock,
  input logic               reset,
  rtc_bus_engine_if.master  bus
);
  rtc_state_e state_q, state_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0] cap_q, rdata_q;
  rtc_pins_t  pins_q, pins_d;
  logic       ready_q, done_q, done_d;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [7:0] cnt_val;

  rtc_phase_cnt u_phase_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // State register and the command latched at acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: advance a phase when its counter is at zero, loading the next length.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = 8'h00;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = ADDR;
        rw_d     = bus.rw;
        addr_d   = bus.addr;
        wdata_d  = bus.wdata;
        cnt_load = 1'b1;
        cnt_val  = phase_load(T_ALE);
      end
      ADDR:  if (cnt_zero) begin state_d = AHOLD; cnt_load = 1'b1; cnt_val = phase_load(T_AH);   end else cnt_dec = 1'b1;
      AHOLD: if (cnt_zero) begin state_d = TURN;  cnt_load = 1'b1; cnt_val = phase_load(T_TURN); end else cnt_dec = 1'b1;
      TURN:  if (cnt_zero) begin state_d = STB;   cnt_load = 1'b1; cnt_val = phase_load(T_STB);  end else cnt_dec = 1'b1;
      STB:   if (cnt_zero) begin state_d = DHOLD; cnt_load = 1'b1; cnt_val = phase_load(T_DH);   end else cnt_dec = 1'b1;
      DHOLD: if (cnt_zero) begin state_d = REC;   cnt_load = 1'b1; cnt_val = phase_load(T_REC);  end else cnt_dec = 1'b1;
      REC:   if (cnt_zero) begin state_d = IDLE;  done_d = 1'b1; end else cnt_dec = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the phase being entered; reads never drive the bus past AHOLD.
  always_comb begin
    pins_d = PINS_IDLE;
    case (state_d)
      ADDR: begin
        pins_d.cs_n  = 1'b0;
        pins_d.ale   = 1'b1;
        pins_d.ad_oe = 1'b1;
        pins_d.ad_o  = addr_d;
      end
      AHOLD: begin
        pins_d.cs_n  = 1'b0;
        pins_d.ad_oe = 1'b1;
        pins_d.ad_o  = addr_d;
      end
      TURN, STB, DHOLD: begin
        pins_d.cs_n = 1'b0;
        if (!rw_d) begin
          pins_d.ad_oe = 1'b1;
          pins_d.ad_o  = wdata_d;
        end
        if (state_d == STB) begin
          if (rw_d) pins_d.rd_n = 1'b0;
          else      pins_d.wr_n = 1'b0;
        end
      end
      default: pins_d = PINS_IDLE;
    endcase
  end

  // Output registers; read data is captured at the end of the strobe but only
  // published with done, so rdata stays stable until the next read completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pins_q  <= PINS_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      cap_q   <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      pins_q  <= pins_d;
      ready_q <= (state_d == IDLE);
      done_q  <= done_d;
      if ((state_q == STB) && cnt_zero && rw_q) cap_q <= bus.ad_i;
      if (done_d && rw_q) rdata_q <= cap_q;
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.cs_n  = pins_q.cs_n;
  assign bus.ale   = pins_q.ale;
  assign bus.rd_n  = pins_q.rd_n;
  assign bus.wr_n  = pins_q.wr_n;
  assign bus.ad_oe = pins_q.ad_oe;
  assign bus.ad_o  = pins_q.ad_o;
endmodule

// File: tb/tb_rtc_bus_engine.sv
// Bench for rtc_bus_engine: default-timing instance (dut0) and a fast-timing
// instance (dut1, T_STB=1, T_REC=1) checked every cycle against a
// cycle-count schedule model, plus directed literal checks.
module tb_rtc_bus_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_bus_engine_if bif0 ();
  rtc_bus_engine_if bif1 ();

  rtc_bus_engine dut0 (.clock(clk), .reset(rst), .bus(bif0));
  rtc_bus_engine #(.T_STB(1), .T_REC(1)) dut1 (.clock(clk), .reset(rst), .bus(bif1));

  // Chip model: returns the programmed byte only while rd_n is low.
  logic [7:0] cv [2] = '{8'h00, 8'h00};
  assign bif0.ad_i = bif0.rd_n ? 8'hEE : cv[0];
  assign bif1.ad_i = bif1.rd_n ? 8'hEE : cv[1];

  // Phase lengths ALE, AH, TURN, STB, DH, REC per instance.
  int tph [2][6] = '{'{2, 2, 2, 4, 2, 4}, '{2, 2, 2, 1, 2, 1}};

  function automatic int tot(input int d);
    int s = 0;
    for (int p = 0; p < 6; p++) s += tph[d][p];
    return s;
  endfunction

  // Expected {cs_n, ale, rd_n, wr_n, ad_oe, ad_o} in cycle k (1-based) of a transaction.
  function automatic logic [12:0] exp_pins(input int d, input int k, input logic r,
                                           input logic [7:0] a, input logic [7:0] w);
    int b1, b2, b3, b4, b5;
    logic cs, al, rn, wn, oe;
    logic [7:0] ao;
    b1 = tph[d][0]; b2 = b1 + tph[d][1]; b3 = b2 + tph[d][2];
    b4 = b3 + tph[d][3]; b5 = b4 + tph[d][4];
    cs = 1'b1; al = 1'b0; rn = 1'b1; wn = 1'b1; oe = 1'b0; ao = 8'h00;
    if (k <= b5) cs = 1'b0;
    if (k <= b1) al = 1'b1;
    if (k <= b2) begin oe = 1'b1; ao = a; end
    else if (k <= b5 && !r) begin oe = 1'b1; ao = w; end
    if (k > b3 && k <= b4) begin
      if (r) rn = 1'b0; else wn = 1'b0;
    end
    return {cs, al, rn, wn, oe, ao};
  endfunction

  // Model state: busy flag, cycle index within the transaction, latched command.
  bit         m_busy [2] = '{1'b0, 1'b0};
  int         m_k    [2] = '{0, 0};
  logic       m_rw   [2] = '{1'b0, 1'b0};
  logic [7:0] m_addr [2] = '{8'h00, 8'h00};
  logic [7:0] m_wd   [2] = '{8'h00, 8'h00};
  logic [7:0] m_val  [2] = '{8'h00, 8'h00};
  logic [7:0] m_rd   [2] = '{8'h00, 8'h00};

  // Model: accept when idle or in the done cycle; a read's byte appears with done.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0; m_k[d] <= 0; m_rd[d] <= 8'h00;
      end else if ((!m_busy[d] || m_k[d] == tot(d) + 1) && (d == 0 ? bif0.start : bif1.start)) begin
        m_busy[d] <= 1'b1; m_k[d] <= 1;
        m_rw[d]   <= (d == 0) ? bif0.rw    : bif1.rw;
        m_addr[d] <= (d == 0) ? bif0.addr  : bif1.addr;
        m_wd[d]   <= (d == 0) ? bif0.wdata : bif1.wdata;
        m_val[d]  <= cv[d];
      end else if (m_busy[d]) begin
        if (m_k[d] == tot(d) + 1) begin
          m_busy[d] <= 1'b0; m_k[d] <= 0;
        end else begin
          if (m_k[d] == tot(d) && m_rw[d]) m_rd[d] <= m_val[d];
          m_k[d] <= m_k[d] + 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int         done_cnt [2] = '{0, 0};
  int         stb_cnt  [2] = '{0, 0};
  logic [7:0] ale_addr [2] = '{8'h00, 8'h00};

  task automatic chk(input int d, input logic rdy, input logic dn, input logic [7:0] rd,
                     input logic cs, input logic al, input logic rn, input logic wn,
                     input logic oe, input logic [7:0] ao);
    logic [12:0] e;
    logic e_rdy, e_dn;
    if (m_busy[d] && m_k[d] <= tot(d)) begin
      e = exp_pins(d, m_k[d], m_rw[d], m_addr[d], m_wd[d]);
      e_rdy = 1'b0; e_dn = 1'b0;
    end else begin
      e = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
      e_rdy = 1'b1; e_dn = m_busy[d];
    end
    check($sformatf("dut%0d_ready", d), {7'b0, rdy}, {7'b0, e_rdy});
    check($sformatf("dut%0d_done", d),  {7'b0, dn},  {7'b0, e_dn});
    check($sformatf("dut%0d_rdata", d), rd, m_rd[d]);
    check($sformatf("dut%0d_pins", d),  {3'b0, cs, al, rn, wn, oe}, {3'b0, e[12:8]});
    check($sformatf("dut%0d_ad_o", d),  ao, e[7:0]);
    check($sformatf("dut%0d_strobe_overlap", d), {7'b0, ~rn & ~wn}, 8'h00);
    check($sformatf("dut%0d_ale_in_strobe", d),  {7'b0, al & (~rn | ~wn)}, 8'h00);
    check($sformatf("dut%0d_drive_in_read", d),  {7'b0, oe & ~rn}, 8'h00);
    if (!rn || !wn) stb_cnt[d]++;
    if (al) ale_addr[d] = ao;
    if (dn) begin
      done_cnt[d]++;
      $display("dut%0d txn %0d done at cycle %0d rw=%0b addr=%h rdata=%h",
               d, done_cnt[d], cyc, m_rw[d], m_addr[d], rd);
    end
  endtask

  // Single compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    chk(0, bif0.ready, bif0.done, bif0.rdata, bif0.cs_n, bif0.ale, bif0.rd_n, bif0.wr_n, bif0.ad_oe, bif0.ad_o);
    chk(1, bif1.ready, bif1.done, bif1.rdata, bif1.cs_n, bif1.ale, bif1.rd_n, bif1.wr_n, bif1.ad_oe, bif1.ad_o);
  end

  // Issue one command; returns 1 time unit after the accepting edge with inputs scrambled.
  task automatic go(input int d, input logic r, input logic [7:0] a, input logic [7:0] w);
    if (d == 0) begin bif0.rw = r; bif0.addr = a; bif0.wdata = w; bif0.start = 1'b1; end
    else        begin bif1.rw = r; bif1.addr = a; bif1.wdata = w; bif1.start = 1'b1; end
    @(posedge clk); #1;
    if (d == 0) begin bif0.start = 1'b0; bif0.rw = ~r; bif0.addr = ~a; bif0.wdata = ~w; end
    else        begin bif1.start = 1'b0; bif1.rw = ~r; bif1.addr = ~a; bif1.wdata = ~w; end
  endtask

  // Wait (bounded) for done; returns on the falling edge of the done cycle.
  task automatic wait_done(input int d, input int maxc);
    logic seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      seen = (d == 0) ? bif0.done : bif1.done;
    end
    check("done_timeout", {7'b0, seen}, 8'h01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c0, c1, c2, n_low, s0;
    bif0.start = 1'b0; bif0.rw = 1'b0; bif0.addr = 8'h00; bif0.wdata = 8'h00;
    bif1.start = 1'b0; bif1.rw = 1'b0; bif1.addr = 8'h00; bif1.wdata = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {7'b0, bif0.ready}, 8'h01);
    check("rst_cs_n",  {7'b0, bif0.cs_n},  8'h01);
    check("rst_done",  {7'b0, bif0.done},  8'h00);
    check("rst_rdata", bif0.rdata, 8'h00);
    check("rst_oe",    {7'b0, bif0.ad_oe}, 8'h00);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Write 0x23 <= 0x15 with the default schedule, pinned cycle by cycle.
    go(0, 1'b0, 8'h23, 8'h15);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      case (k)
        1:  begin check("t1_ale_c1", {7'b0, bif0.ale}, 8'h01); check("t1_addr_c1", bif0.ad_o, 8'h23); end
        2:  check("t1_ale_c2", {7'b0, bif0.ale}, 8'h01);
        3:  begin check("t1_ale_c3", {7'b0, bif0.ale}, 8'h00); check("t1_addr_c3", bif0.ad_o, 8'h23); end
        6:  check("t1_wr_n_c6", {7'b0, bif0.wr_n}, 8'h01);
        7:  begin check("t1_wr_n_c7", {7'b0, bif0.wr_n}, 8'h00); check("t1_data_c7", bif0.ad_o, 8'h15);
                  check("t1_oe_c7", {7'b0, bif0.ad_oe}, 8'h01); end
        10: check("t1_wr_n_c10", {7'b0, bif0.wr_n}, 8'h00);
        11: check("t1_wr_n_c11", {7'b0, bif0.wr_n}, 8'h01);
        12: check("t1_cs_n_c12", {7'b0, bif0.cs_n}, 8'h00);
        13: check("t1_cs_n_c13", {7'b0, bif0.cs_n}, 8'h01);
        16: begin check("t1_cs_n_c16", {7'b0, bif0.cs_n}, 8'h01); check("t1_done_c16", {7'b0, bif0.done}, 8'h00); end
        17: begin check("t1_done_c17", {7'b0, bif0.done}, 8'h01); check("t1_ready_c17", {7'b0, bif0.ready}, 8'h01); end
        default: ;
      endcase
    end

    // Read 0x21, chip returns 0x59; then a write must not disturb rdata.
    @(posedge clk); #1;
    cv[0] = 8'h59;
    n_low = 0;
    go(0, 1'b1, 8'h21, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (!bif0.rd_n) begin
        n_low++;
        check("t2_oe_during_rd", {7'b0, bif0.ad_oe}, 8'h00);
      end
      if (k == 17) begin
        check("t2_done", {7'b0, bif0.done}, 8'h01);
        check("t2_rdata", bif0.rdata, 8'h59);
      end
    end
    check("t2_rd_low_cycles", 8'(n_low), 8'd4);
    @(posedge clk); #1;
    go(0, 1'b0, 8'h26, 8'h99);
    wait_done(0, 40);
    check("t2_rdata_held", bif0.rdata, 8'h59);

    // Back-to-back with start held high: write 0x22/0x30 then read 0x24.
    @(posedge clk); #1;
    n0 = done_cnt[0];
    bif0.rw = 1'b0; bif0.addr = 8'h22; bif0.wdata = 8'h30; bif0.start = 1'b1;
    @(posedge clk); #1;
    bif0.rw = 1'b1; bif0.addr = 8'h24; bif0.wdata = 8'h00; cv[0] = 8'h6B;
    wait_done(0, 40);
    c1 = cyc;
    @(posedge clk); #1;
    bif0.start = 1'b0; bif0.addr = 8'h55;
    @(negedge clk);
    check("t3_second_ale", {7'b0, bif0.ale}, 8'h01);
    check("t3_second_addr", bif0.ad_o, 8'h24);
    wait_done(0, 40);
    c2 = cyc;
    check("t3_done_spacing", 8'(c2 - c1), 8'd17);
    check("t3_rdata", bif0.rdata, 8'h6B);
    #1 check("t3_done_count", 8'(done_cnt[0] - n0), 8'd2);

    // Start pulsed during cycle 5 of a write to 0x25 must be ignored.
    @(posedge clk); #1;
    n0 = done_cnt[0];
    go(0, 1'b0, 8'h25, 8'h12);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    bif0.start = 1'b1; bif0.rw = 1'b1; bif0.addr = 8'h41; bif0.wdata = 8'hEE;
    @(posedge clk); #1;
    bif0.start = 1'b0;
    wait_done(0, 40);
    repeat (20) @(negedge clk);
    #1;
    check("t4_done_count", 8'(done_cnt[0] - n0), 8'd1);
    check("t4_latched_addr", ale_addr[0], 8'h25);

    // Reset during the write strobe: pins drop at once, no done, then recovery.
    @(posedge clk); #1;
    n0 = done_cnt[0];
    go(0, 1'b0, 8'h24, 8'h07);
    repeat (8) @(negedge clk);
    check("t5_in_strobe", {7'b0, bif0.wr_n}, 8'h00);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_cs_n",  {7'b0, bif0.cs_n},  8'h01);
    check("t5_rst_wr_n",  {7'b0, bif0.wr_n},  8'h01);
    check("t5_rst_oe",    {7'b0, bif0.ad_oe}, 8'h00);
    check("t5_rst_ready", {7'b0, bif0.ready}, 8'h01);
    #1 rst = 1'b0;
    repeat (25) @(negedge clk);
    #1 check("t5_no_done", 8'(done_cnt[0] - n0), 8'd0);
    @(posedge clk); #1;
    cv[0] = 8'h3C;
    go(0, 1'b1, 8'h00, 8'h00);
    wait_done(0, 40);
    check("t5_rdata_after", bif0.rdata, 8'h3C);

    // Short timing instance: latency 11, one-cycle strobe.
    @(posedge clk); #1;
    s0 = stb_cnt[1];
    go(1, 1'b0, 8'h43, 8'hA7);
    c0 = cyc;
    wait_done(1, 30);
    check("t6_write_latency", 8'(cyc - c0 + 1), 8'd11);
    @(posedge clk); #1;
    cv[1] = 8'h81;
    go(1, 1'b1, 8'hF0, 8'h00);
    c0 = cyc;
    wait_done(1, 30);
    check("t6_read_latency", 8'(cyc - c0 + 1), 8'd11);
    check("t6_rdata", bif1.rdata, 8'h81);
    #1 check("t6_strobe_cycles", 8'(stb_cnt[1] - s0), 8'd2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
